// File: rtl/axis_pkg.sv
// Shared AXI4-Stream beat layout and constants for the
// stream master, slave and frame FIFO.
package axis_pkg;

   localparam int AXIS_DW   = 32;
   localparam int AXIS_SB_W = 2;

   typedef struct packed {
      logic               user;
      logic               last;
      logic [AXIS_DW-1:0] data;
   } axis_beat_t;

   function automatic int beat_w(input int dw);
      return dw + AXIS_SB_W;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Beat storage for the frame FIFO: one synchronous write port,
// one asynchronous read port so the head beat falls through.
module sync_fifo_mem #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_frame_fifo.sv
// First-word-fall-through AXI4-Stream FIFO that counts whole
// frames held and flags a SOF arriving inside an open frame.
module axis_frame_fifo
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DW,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tuser,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [$clog2(DEPTH+1)-1:0] frames,
   output logic                       sof_err,
   input  logic                       err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int BW = beat_w(DATA_WIDTH);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_frames;
   logic          r_in_frame;
   logic          r_sof_err;
   logic          r_s_tready;

   logic [LW-1:0] w_level;
   logic [LW-1:0] w_lvl_nxt;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_head_last;
   logic [BW-1:0] w_wdata;
   logic [BW-1:0] w_rdata;

   assign w_level = LW'(r_wr_ptr - r_rd_ptr);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_push = s_axis_tvalid & r_s_tready & ~w_full;
   assign w_pop  = ~w_empty & m_axis_tready;

   assign w_lvl_nxt = w_level + LW'(w_push) - LW'(w_pop);

   assign w_wdata = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
   assign w_head_last = w_rdata[DATA_WIDTH];

   sync_fifo_mem #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_s_tready <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_s_tready <= (w_lvl_nxt < LW'(DEPTH));
      end
   end

   // A pushed SOF while a frame is open is still stored; it only raises the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frames   <= '0;
         r_in_frame <= 1'b0;
         r_sof_err  <= 1'b0;
      end else begin
         r_frames <= r_frames
                   + LW'(w_push & s_axis_tlast)
                   - LW'(w_pop & w_head_last);
         if (w_push) r_in_frame <= ~s_axis_tlast;
         if (w_push & s_axis_tuser & r_in_frame)
            r_sof_err <= 1'b1;
         else if (err_clr)
            r_sof_err <= 1'b0;
      end
   end

   assign s_axis_tready = r_s_tready;
   assign m_axis_tvalid = ~w_empty;
   assign m_axis_tdata  = w_empty ? '0 : w_rdata[DATA_WIDTH-1:0];
   assign m_axis_tlast  = ~w_empty & w_rdata[DATA_WIDTH];
   assign m_axis_tuser  = ~w_empty & w_rdata[DATA_WIDTH+1];
   assign level         = w_level;
   assign frames        = r_frames;
   assign sof_err       = r_sof_err;

endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Synchronous AXI4-Stream FIFO with frame sideband (tlast/tuser) that sits directly downstream of the AXI-Stream master and upstream of the AXI-Stream slave. It decouples producer and consumer back-pressure and buffers up to DEPTH beats. It tracks the number of complete frames held and flags framing errors (start-of-frame arriving mid-frame).

## Interface
- DATA_WIDTH, 32, tdata width in bits
- DEPTH, 16, entries; power of two, >= 2
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  DATA_WIDTH  upstream data
- s_axis_tvalid  input  1  upstream valid
- s_axis_tready  output  1  FIFO can accept a beat
- s_axis_tlast  input  1  last beat of frame
- s_axis_tuser  input  1  first beat of frame (SOF)
- m_axis_tdata  output  DATA_WIDTH  head-of-FIFO data
- m_axis_tvalid  output  1  FIFO non-empty
- m_axis_tready  input  1  downstream accepts
- m_axis_tlast  output  1  head-of-FIFO tlast
- m_axis_tuser  output  1  head-of-FIFO tuser
- level  output  $clog2(DEPTH+1)  beats currently stored
- frames  output  $clog2(DEPTH+1)  complete frames (tlast beats) stored
- sof_err  output  1  sticky framing-error flag
- err_clr  input  1  synchronous clear of sof_err

## Operation
- Push: s_axis_tvalid & s_axis_tready; store {tuser, tlast, tdata} at wr_ptr, wr_ptr++.
- Pop: m_axis_tvalid & m_axis_tready; rd_ptr++.
- Pointers are $clog2(DEPTH)+1 bits; wrap naturally; full = MSBs differ and LSBs equal; empty = pointers equal.
- level = wr_ptr - rd_ptr (modulo arithmetic), range 0..DEPTH.
- Output is first-word-fall-through: m_axis_* show mem[rd_ptr] whenever level != 0; m_axis_tvalid = (level != 0).
- s_axis_tready is registered: high when next level < DEPTH; independent of m_axis_tready (no ready pass-through).
- Simultaneous push and pop: both occur; level unchanged. When full, no push that cycle even if a pop occurs; tready rises the following cycle.
- frames: +1 on pushed tlast beat, -1 on popped tlast beat; both in the same cycle -> unchanged.
- Frame tracker (input side): in_frame set on a pushed beat with tlast=0, cleared on a pushed beat with tlast=1. A pushed beat with tuser=1 while in_frame=1 sets sof_err. The beat is still stored unchanged.
- err_clr clears sof_err; a same-cycle new error wins (sof_err stays 1).
- Data held while m_axis_tvalid & !m_axis_tready: m_axis_* must remain stable (AXI rule).

## Timing
- Reset (rst_n low, async): pointers 0, level 0, frames 0, in_frame 0, sof_err 0, s_axis_tready 0, m_axis_tvalid 0; m_axis_tdata/tlast/tuser 0 (memory contents don't care, outputs gated to 0 when empty).
- s_axis_tready rises on the first clk edge after rst_n deasserts.
- Latency: beat pushed at edge N is visible on m_axis_* after edge N (valid in cycle N+1). Throughput is 1 beat/cycle sustained with both sides ready.
- level/frames/sof_err are registered and update on the same edge as the push/pop that causes them.
- Reset mid-frame discards all contents; the first beat after reset is not checked against the pre-reset in_frame.

## Structure
- Package axis_pkg: typedef axis_beat_t struct {user, last, data[DATA_WIDTH-1:0]} and shared AXIS constants; shared with master/slave.
- Sub-module sync_fifo_mem (DEPTH x beat width, 1 write port, 1 async read port); pointer, level, frame and error logic live in axis_frame_fifo.

## Test plan
- Reset, then push 4 beats 0x12345678, 0xDEADBEEF, 0xFACEFADE, 0xABEDDEAF (tuser on first, tlast on last) with m_axis_tready=1 -> same sequence out, 1-cycle latency, frames returns to 0, sof_err=0.
- m_axis_tready=0, push DEPTH=16 beats -> level=16, s_axis_tready=0 at cycle after 16th push. A 17th beat is held upstream, not lost.
- Full, then m_axis_tready=1 with s_axis_tvalid=1 continuous -> one pop with no push. Then steady push+pop, level holds 15/16, no beat dropped or duplicated.
- Push burst 0xDEADBEEF..0xDEADBEF3 (5 beats, tlast on 5th) while downstream stalled -> frames=1 after 5th push, 0 after 5th pop.
- Push tuser=1 beat, then tuser=1 beat without intervening tlast -> sof_err=1 next cycle, both beats delivered; err_clr pulse -> sof_err=0.
- Assert rst_n low mid-burst with level=3 -> all outputs at reset values immediately (async), no stale beat output after release.
